// File: rtl/vr_vc_converter_pkg.sv
// Shared types and helpers for the valid/ready to valid/credit converter.
package vr_vc_converter_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_CREDIT_NUM = 2;

   // Credit counter update selected each cycle from the inc/dec pair.
   typedef enum logic [1:0] {
      CR_HOLD = 2'd0,
      CR_INC  = 2'd1,
      CR_DEC  = 2'd2
   } credit_op_e;

   // Width of a counter that must hold every value from 0 to n inclusive.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/vr_vc_converter_if.sv
// Upstream valid/ready and downstream valid/credit signal bundle.
// slave: the converter side. master: the side that drives the upstream
// beat and the receiver's credit returns.
interface vr_vc_converter_if
   import vr_vc_converter_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CREDIT_NUM = DEF_CREDIT_NUM
);
   localparam int CNT_W = cnt_width(CREDIT_NUM);

   logic [DATA_WIDTH-1:0] s_data_i;
   logic                  s_valid_i;
   logic                  s_ready_o;
   logic [DATA_WIDTH-1:0] m_data_o;
   logic                  m_valid_o;
   logic                  m_credit_i;
   logic [CNT_W-1:0]      credit_cnt_o;
   logic                  credit_ovf_o;

   modport slave (
      input  s_data_i, s_valid_i, m_credit_i,
      output s_ready_o, m_data_o, m_valid_o, credit_cnt_o, credit_ovf_o
   );

   modport master (
      output s_data_i, s_valid_i, m_credit_i,
      input  s_ready_o, m_data_o, m_valid_o, credit_cnt_o, credit_ovf_o
   );

endinterface

// File: rtl/vc_credit_counter.sv
// Saturating credit counter with a sticky overflow flag.
// Starts empty; credits are only learned from inc pulses. A simultaneous
// inc and dec cancel. An inc at MAX saturates and raises ovf until reset.
module vc_credit_counter
   import vr_vc_converter_pkg::*;
#(
   parameter  int MAX = DEF_CREDIT_NUM,
   localparam int W   = cnt_width(MAX)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         ovf
);

   localparam logic [W-1:0] MAX_C = W'(MAX);

   credit_op_e op;

   // Reduce the inc/dec pair to a single counter operation.
   always_comb begin
      op = CR_HOLD;
      case ({inc, dec})
         2'b10:   op = CR_INC;
         2'b01:   op = CR_DEC;
         default: op = CR_HOLD;
      endcase
   end

   // Counter and sticky overflow register; dec at zero is ignored defensively.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         case (op)
            CR_INC: begin
               if (cnt == MAX_C) ovf <= 1'b1;
               else              cnt <= cnt + W'(1);
            end
            CR_DEC: begin
               if (cnt != '0) cnt <= cnt - W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/vr_vc_converter.sv
// Valid/ready to valid/credit converter.
// Upstream beats are accepted only while credits are held; each accepted
// beat is registered and emitted downstream one cycle later as a
// single-cycle m_valid_o pulse.
module vr_vc_converter
   import vr_vc_converter_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CREDIT_NUM = DEF_CREDIT_NUM
) (
   input  logic               clk,
   input  logic               rst_n,
   vr_vc_converter_if.slave   bus
);

   localparam int CNT_W = cnt_width(CREDIT_NUM);

   logic [CNT_W-1:0]      cnt;
   logic                  ovf;
   logic                  hs;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;

   // Ready comes from the registered counter alone, so a credit returned
   // at zero only opens the gate on the following cycle.
   assign bus.s_ready_o = (cnt != '0);
   assign hs            = bus.s_valid_i & bus.s_ready_o;

   vc_credit_counter #(
      .MAX (CREDIT_NUM)
   ) u_credit (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (bus.m_credit_i),
      .dec   (hs),
      .cnt   (cnt),
      .ovf   (ovf)
   );

   // Downstream beat register: data loads on handshake and holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= hs;
         if (hs) data_q <= bus.s_data_i;
      end
   end

   assign bus.m_data_o     = data_q;
   assign bus.m_valid_o    = valid_q;
   assign bus.credit_cnt_o = cnt;
   assign bus.credit_ovf_o = ovf;

endmodule
